// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_driver
// Description : Command-side driver for a 4-bit combinational ALU.
//               Host commands (operands, opcode, shift-input select) are
//               buffered in a DEPTH-entry FIFO. They are issued one at a
//               time onto registered ALU inputs. The ALU result and carry
//               are captured one cycle later and returned in order on a
//               valid/ready response channel.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH       command FIFO depth in entries (power of two, >= 2)
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   cmd_valid   host command valid
//   cmd_ready   FIFO can accept a command (not full)
//   cmd_a/b     4-bit operands
//   cmd_op      3-bit ALU opcode
//   cmd_sel     shift-input select
//   alu_a/b     registered operands to the ALU
//   alu_opcode  registered opcode to the ALU
//   alu_in_sel  registered shift-input select to the ALU
//   alu_out     ALU result
//   alu_carry   ALU carry
//   rsp_valid   response valid
//   rsp_ready   host accepts the response
//   rsp_out     captured result
//   rsp_carry   captured carry
//   rsp_op      opcode that produced the response
//   busy        FSM not idle or FIFO non-empty
//   cmd_count   FIFO occupancy
// Configuration
//   ALU_CMD_DRV_SKIP_NOP_EN  when defined, popped opcode-000 commands are
//                            discarded without driving the ALU or responding.
// ============================================================================
module alu_cmd_driver #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic [2:0]               cmd_op,
  input  logic                     cmd_sel,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_opcode,
  output logic                     alu_in_sel,
  input  logic [3:0]               alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [3:0]               rsp_out,
  output logic                     rsp_carry,
  output logic [2:0]               rsp_op,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO. Entry layout: {sel, op[2:0], b[3:0], a[3:0]}.
  // Pointers are exactly AW bits wide so wrap-around is free for a
  // power-of-two depth; occupancy is tracked separately.
  // --------------------------------------------------------------------------
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;
  logic          w_head_nop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Readiness depends on occupancy only; a same-cycle pop does not free a slot
  assign w_push  = cmd_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

`ifdef ALU_CMD_DRV_SKIP_NOP_EN
  assign w_head_nop = (w_head[10:8] == 3'b000);
`else
  assign w_head_nop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_sel, cmd_op, cmd_b, cmd_a};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_next;
  logic   w_load;
  logic   w_capture;
  logic   w_rsp_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_rsp_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          // A skipped NOP is consumed here and the FSM stays idle
          if (!w_head_nop) begin
            w_load = 1'b1;
            w_next = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        w_capture = 1'b1;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        // rsp_valid is always high in this state, so rsp_ready alone is
        // the handshake
        if (rsp_ready) begin
          w_rsp_clear = 1'b1;
          w_next      = ST_IDLE;
          if (!w_empty) begin
            w_pop = 1'b1;
            if (!w_head_nop) begin
              w_load = 1'b1;
              w_next = ST_DRIVE;
            end
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU drive registers: they hold the last issued command when idle
  // --------------------------------------------------------------------------
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [2:0] r_alu_opcode;
  logic       r_alu_in_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_alu_in_sel <= 1'b0;
    end else if (w_load) begin
      r_alu_a      <= w_head[3:0];
      r_alu_b      <= w_head[7:4];
      r_alu_opcode <= w_head[10:8];
      r_alu_in_sel <= w_head[11];
    end
  end

  // --------------------------------------------------------------------------
  // Response registers. The ALU sits combinationally between the drive
  // registers and these, so capture happens at the end of DRIVE.
  // --------------------------------------------------------------------------
  logic       r_rsp_valid;
  logic [3:0] r_rsp_out;
  logic       r_rsp_carry;
  logic [2:0] r_rsp_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_op    <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_out   <= alu_out;
      r_rsp_carry <= alu_carry;
      r_rsp_op    <= r_alu_opcode;
    end else if (w_rsp_clear) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_ready  = !w_full;
  assign cmd_count  = r_count;
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign alu_in_sel = r_alu_in_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_out    = r_rsp_out;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_op     = r_rsp_op;

endmodule
`default_nettype wire
